// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel PWM: register map and counting mode.
package pwm_multi_pkg;

    localparam int unsigned ADDR_OUT_EN    = 0;
    localparam int unsigned ADDR_PWM_EN    = 1;
    localparam int unsigned ADDR_PRESC     = 2;
    localparam int unsigned ADDR_MODE      = 3;
    localparam int unsigned ADDR_DUTY_BASE = 4;

    typedef enum logic [0:0] {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus up (edge) or up/down (center) period counter with boundary detection.
module pwm_timebase
    import pwm_multi_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PRESC_W-1:0] prescale,
    input  pwm_mode_e          mode,
    output logic [CNT_W-1:0]   cnt,
    output logic               boundary
);

    // Counter tops out at MAX-1 so a full-scale duty never drops out at wrap.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_MAX - 1'b1;

    logic [PRESC_W-1:0] psc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               down_q;
    logic               tick;

    always_comb begin
        tick     = (psc_q == prescale);
        boundary = 1'b0;
        if (tick) begin
            if (mode == MODE_EDGE) begin
                boundary = (cnt_q == CNT_TOP);
            end else begin
                boundary = down_q && (cnt_q == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psc_q  <= '0;
            cnt_q  <= '0;
            down_q <= 1'b0;
        end else if (boundary) begin
            psc_q  <= '0;
            cnt_q  <= '0;
            down_q <= 1'b0;
        end else if (tick) begin
            psc_q <= '0;
            if (mode == MODE_EDGE) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!down_q) begin
                // The top value is held for a second tick as the direction turns.
                if (cnt_q == CNT_TOP) begin
                    down_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end else begin
            psc_q <= psc_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: config register file with shadow->active transfer at period boundaries,
// per-channel comparators and registered output mux.
module pwm_multi_channel
    import pwm_multi_pkg::*;
#(
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PRESC_W = 8,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned WDATA_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [WDATA_W-1:0] cfg_wdata,
    output logic [NUM_CH-1:0]  out,
    output logic               period_start
);

    logic [31:0] addr_ext;
    logic [31:0] duty_idx;
    logic        duty_hit;
    logic        wr_out_en;
    logic        wr_pwm_en;
    logic        wr_presc;
    logic        wr_mode;
    logic [NUM_CH-1:0] wr_duty;

    logic [NUM_CH-1:0]  out_en_q;
    logic [NUM_CH-1:0]  pwm_en_sh_q, pwm_en_act_q, pwm_en_d;
    logic [PRESC_W-1:0] presc_sh_q, presc_act_q, presc_d;
    pwm_mode_e          mode_sh_q, mode_act_q, mode_d;
    logic [CNT_W-1:0]   duty_sh_q  [NUM_CH];
    logic [CNT_W-1:0]   duty_act_q [NUM_CH];
    logic [CNT_W-1:0]   duty_d     [NUM_CH];

    logic [CNT_W-1:0]  cnt;
    logic              boundary;
    logic [NUM_CH-1:0] out_d;
    logic [NUM_CH-1:0] out_q;
    logic              start_q;
    logic              period_start_q;

    always_comb begin
        addr_ext  = 32'(cfg_addr);
        duty_idx  = addr_ext - ADDR_DUTY_BASE;
        duty_hit  = cfg_we && (addr_ext >= ADDR_DUTY_BASE) &&
                    (addr_ext < ADDR_DUTY_BASE + NUM_CH);
        wr_out_en = cfg_we && (addr_ext == ADDR_OUT_EN);
        wr_pwm_en = cfg_we && (addr_ext == ADDR_PWM_EN);
        wr_presc  = cfg_we && (addr_ext == ADDR_PRESC);
        wr_mode   = cfg_we && (addr_ext == ADDR_MODE);
        for (int i = 0; i < NUM_CH; i++) begin
            wr_duty[i] = duty_hit && (duty_idx == unsigned'(i));
        end
    end

    // Next shadow values; also what the active copy takes at a boundary, so a write
    // landing on the boundary cycle is used by the very next period.
    always_comb begin
        pwm_en_d = wr_pwm_en ? cfg_wdata[NUM_CH-1:0] : pwm_en_sh_q;
        presc_d  = wr_presc ? cfg_wdata[PRESC_W-1:0] : presc_sh_q;
        mode_d   = wr_mode ? pwm_mode_e'(cfg_wdata[0]) : mode_sh_q;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_d[i] = wr_duty[i] ? cfg_wdata[CNT_W-1:0] : duty_sh_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_en_q     <= '0;
            pwm_en_sh_q  <= '0;
            pwm_en_act_q <= '0;
            presc_sh_q   <= '0;
            presc_act_q  <= '0;
            mode_sh_q    <= MODE_EDGE;
            mode_act_q   <= MODE_EDGE;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            if (wr_out_en) begin
                out_en_q <= cfg_wdata[NUM_CH-1:0];
            end
            pwm_en_sh_q <= pwm_en_d;
            presc_sh_q  <= presc_d;
            mode_sh_q   <= mode_d;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i] <= duty_d[i];
            end
            if (boundary) begin
                pwm_en_act_q <= pwm_en_d;
                presc_act_q  <= presc_d;
                mode_act_q   <= mode_d;
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_act_q[i] <= duty_d[i];
                end
            end
        end
    end

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk      (clk),
        .rst_n    (rst_n),
        .prescale (presc_act_q),
        .mode     (mode_act_q),
        .cnt      (cnt),
        .boundary (boundary)
    );

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!out_en_q[i]) begin
                out_d[i] = 1'b0;
            end else if (!pwm_en_act_q[i]) begin
                out_d[i] = 1'b1;
            end else begin
                out_d[i] = (cnt < duty_act_q[i]);
            end
        end
    end

    // start_q marks the first counter cycle of a period; it is delayed once more so
    // period_start lines up with the registered output of that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q          <= '0;
            start_q        <= 1'b1;
            period_start_q <= 1'b0;
        end else begin
            out_q          <= out_d;
            start_q        <= boundary;
            period_start_q <= start_q;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Parametrised multi-channel PWM peripheral, next generation of the onboarding PWM block. It adds per-channel duty cycles, a configurable counter width, a clock prescaler and an edge/center-aligned mode. Register updates are double-buffered so new settings take effect only at a period boundary, giving glitch-free waveforms. It sits behind the project's configuration write port (SPI register front-end) and drives the top-level `uo_out`/`uio_out` pins.

## Interface
- `NUM_CH`, 16, number of PWM channels/output pins.
- `CNT_W`, 8, duty/counter width; MAX = 2^CNT_W − 1.
- `PRESC_W`, 8, prescaler width.
- `ADDR_W`, 5, config address width; requires 4 + NUM_CH ≤ 2^ADDR_W.
- `WDATA_W`, 16, config data width; requires NUM_CH, CNT_W, PRESC_W ≤ WDATA_W.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `cfg_we` in 1: write strobe, one write per cycle.
- `cfg_addr` in ADDR_W: register address.
- `cfg_wdata` in WDATA_W: write data. Only the field's low bits are used.
- `out` out NUM_CH: registered PWM outputs.
- `period_start` out 1: one-cycle pulse, registered, on the first cycle of each period.

## Operation
- Register map:
  - 0 `out_en[NUM_CH]`
  - 1 `pwm_en[NUM_CH]`
  - 2 `prescale[PRESC_W]`
  - 3 `mode[0]` (0 = edge, 1 = center)
  - 4..4+NUM_CH−1 `duty[ch][CNT_W]`
  - Unmapped addresses are ignored.
- `out_en` applies directly. All other fields are shadow registers, copied into active registers at a boundary.
- If a write coincides with a boundary, the active copy takes the newly written value.
- Prescaler: `psc` counts 0..prescale_active and produces `tick` when `psc == prescale_active`.
- Edge mode:
  - `cnt` counts 0..MAX−1 on each tick, then wraps to 0.
  - Boundary = tick with `cnt == MAX−1`.
  - Period = MAX·(prescale+1) clocks.
- Center mode:
  - `cnt` sequence 0,1..MAX−1,MAX−1..1,0, then repeats; each turnaround value is held for two ticks.
  - Boundary = tick ending the down phase at 0.
  - Period = 2·MAX·(prescale+1) clocks.
- At a boundary, `psc` and `cnt` restart at 0, counting up. This also applies when the mode changes.
- Per-channel wave = `cnt < duty_active[ch]`.
  - duty 0 → constant 0.
  - duty MAX → constant 1.
  - Edge mode: high for duty ticks of every MAX ticks.
  - Center mode: high for 2·duty ticks, centered on the cnt=0 turnaround.
- `out[ch]`:
  - `out_en` = 0 → 0.
  - `out_en` = 1 and `pwm_en_active` = 0 → 1.
  - `out_en` = 1 and `pwm_en_active` = 1 → wave.

## Timing
- Reset (`rst_n` low at a clk edge), including mid-period:
  - All shadow and active registers, `psc` and `cnt` → 0; mode → edge.
  - `out` = 0 and `period_start` = 0 on the cycle after the edge.
- After reset, the first period starts at `cnt` = 0 with all-zero settings.
- Latencies:
  - `out` reflects the counter state with 1 cycle latency.
  - An `out_en` write is visible on `out` 1 cycle after the write edge.
  - Shadowed fields are visible from the first cycle of the next period.
- `period_start` is asserted in the same cycle that `out` shows the first value of the new period.
- prescale = 0 → `tick` every clock; prescale = P → `tick` every P+1 clocks.
- The counter never reaches MAX, so a 100 % duty has no single-cycle dropout at wrap.

## Structure
- Package `pwm_multi_pkg`:
  - Register address constants (ADDR_OUT_EN, ADDR_PWM_EN, ADDR_PRESC, ADDR_MODE, ADDR_DUTY_BASE).
  - `pwm_mode_e` enum {MODE_EDGE, MODE_CENTER}.
- Sub-module `pwm_timebase` contains:
  - Prescaler.
  - Up/up-down counter and its direction flag.
  - `tick`/boundary generation from `prescale_active` and `mode_active`.
- The top level holds the register file, shadow→active transfer, per-channel comparators and the output mux.

## Test plan
- Reset: run center mode with duty[0]=100, then assert `rst_n` low for 2 cycles → `out` = 0 and `period_start` = 0 the next cycle; after release, `cnt` restarts at 0 and all registers read 0 in effect.
- Static: write `out_en` = 0x0001 with `pwm_en` = 0 → `out` = 0x0001 one cycle after the write; other bits stay 0.
- Edge, prescale 0: set duty[3]=128 and `out_en`/`pwm_en` bit 3 → after the next boundary, `out[3]` is high exactly 128 of every 255 clocks; `period_start` pulses every 255 clocks.
- Extremes: duty[1]=0, duty[2]=255 over 3 periods → `out[1]` constant 0 and `out[2]` constant 1 with no glitch at wrap.
- Center mode, prescale 1, duty[5]=64 → period is 1020 clocks; `out[5]` is high for 256 contiguous clocks centered on the cnt=0 turnaround.
- Double-buffering:
  - Write duty[3]=32 mid-period → the current period keeps 128 high clocks; the next period has 32.
  - A write landing on the boundary cycle → takes effect in the immediately following period.
